// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port shared by ALU, load and mul/div units.
// Optional simulation trace of every transfer when WB_TRACE_EN is defined.
module wb_port_arbiter #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [XLEN-1:0]  md_data,
  output logic             md_ready,
  input  logic             clr_cnt,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [1:0]       wb_src,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] SrcNone = 2'd3;

  logic [2:0]      valid;
  logic [2:0]      ready;
  logic [1:0]      ptr_q, ptr_d;
  logic            xfer;
  logic [1:0]      sel_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            conflict;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [1:0]      wb_src_q;
  logic [CNT_W-1:0] cnt_q;

  assign valid = {md_valid, ld_valid, alu_valid};

  // Search order starts at ptr_q and wraps; first valid requester wins.
  always_comb begin
    ready = 3'b000;
    unique case (ptr_q)
      2'd1: begin
        if (valid[1])      ready = 3'b010;
        else if (valid[2]) ready = 3'b100;
        else if (valid[0]) ready = 3'b001;
      end
      2'd2: begin
        if (valid[2])      ready = 3'b100;
        else if (valid[0]) ready = 3'b001;
        else if (valid[1]) ready = 3'b010;
      end
      default: begin
        if (valid[0])      ready = 3'b001;
        else if (valid[1]) ready = 3'b010;
        else if (valid[2]) ready = 3'b100;
      end
    endcase
  end

  assign alu_ready = ready[0];
  assign ld_ready  = ready[1];
  assign md_ready  = ready[2];
  assign xfer      = |ready;

  always_comb begin
    sel_idx  = 2'd0;
    sel_rd   = alu_rd;
    sel_data = alu_data;
    ptr_d    = ptr_q;
    unique case (ready)
      3'b001: begin
        sel_idx  = 2'd0;
        sel_rd   = alu_rd;
        sel_data = alu_data;
        ptr_d    = 2'd1;
      end
      3'b010: begin
        sel_idx  = 2'd1;
        sel_rd   = ld_rd;
        sel_data = ld_data;
        ptr_d    = 2'd2;
      end
      3'b100: begin
        sel_idx  = 2'd2;
        sel_rd   = md_rd;
        sel_data = md_data;
        ptr_d    = 2'd0;
      end
      default: ;
    endcase
  end

  assign conflict = (valid[0] & valid[1]) | (valid[0] & valid[2]) | (valid[1] & valid[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      wb_src_q   <= SrcNone;
    end else if (xfer && (sel_rd != 5'd0)) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= sel_rd;
      rf_wdata_q <= sel_data;
      wb_src_q   <= sel_idx;
    end else begin
      rf_we_q    <= 1'b0;
      wb_src_q   <= SrcNone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign wb_src       = wb_src_q;
  assign conflict_cnt = cnt_q;

`ifdef WB_TRACE_EN
  logic [63:0] trace_cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_cyc_q <= '0;
    end else begin
      trace_cyc_q <= trace_cyc_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && xfer) begin
      if (sel_rd == 5'd0) begin
        $display("[%0d] wb %s x0 dropped", trace_cyc_q,
                 (sel_idx == 2'd0) ? "alu" : (sel_idx == 2'd1) ? "ld" : "md");
      end else begin
        $display("[%0d] wb %s rd=%0d data=%0d", trace_cyc_q,
                 (sel_idx == 2'd0) ? "alu" : (sel_idx == 2'd1) ? "ld" : "md",
                 sel_rd, sel_data);
      end
    end
  end
`else
  // Trace disabled: no simulation-only logic is compiled.
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Sequences the single register-file write port between the three result producers of the pipelined core: ALU, load unit and multiply/divide unit. Each cycle it round-robin grants one valid requester, completes that requester's valid/ready handshake, and registers the selected destination and data onto the register-file write port one cycle later. It also suppresses writes to x0 and counts write-port conflict cycles for performance analysis.

## Interface
- XLEN, 64, data width of results and register-file write data.
- CNT_W, 16, width of the conflict counter.

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result pending.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_valid / ld_rd / ld_data / ld_ready  in/in/in/out  1/5/XLEN/1  same, load unit.
- md_valid / md_rd / md_data / md_ready  in/in/in/out  1/5/XLEN/1  same, mul/div unit.
- clr_cnt  in  1  synchronous clear of conflict_cnt.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- wb_src  out  2  source of current write: 0 ALU, 1 load, 2 mul/div, 3 none.
- conflict_cnt  out  CNT_W  cycles with two or more valid requests.

## Operation
- Requester indices: ALU 0, load 1, mul/div 2.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. A requester holds valid, rd and data stable until ready. It must not drop valid before ready.
- Grant is combinational from the current valids and the priority pointer `ptr` (2-bit state, values 0..2).
- The search order starts at `ptr` and wraps modulo 3. The first valid requester gets ready=1; all others get ready=0.
- With no requester valid, all ready outputs are 0.
- On a transfer from index i, `ptr` becomes (i+1) mod 3. Without a transfer, `ptr` holds.
- Registered write stage, updated every cycle:
  - Transfer with rd≠0: rf_we=1, rf_waddr=rd, rf_wdata=data, wb_src=i.
  - Transfer with rd=0: handshake completes and `ptr` advances. rf_we=0, wb_src=3, rf_waddr and rf_wdata hold.
  - No transfer: rf_we=0, wb_src=3, rf_waddr and rf_wdata hold.
- conflict_cnt:
  - Increments by 1 in each cycle with two or more valids high.
  - Saturates at 2^CNT_W−1.
  - clr_cnt forces it to 0 and wins over a simultaneous increment.
- Ordering between requesters that target the same rd is guaranteed by the upstream scoreboard. The arbiter applies only the grant rule above.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=3, conflict_cnt=0.
  - ready outputs follow the combinational rule with ptr=0.
- Latency: a handshake in cycle T appears on the rf_* and wb_src outputs in cycle T+1, high for exactly one cycle per transfer.
- Throughput: one write per cycle. A continuously valid requester waits at most 2 cycles between grants.
- Reset mid-operation: the registered write in flight is dropped (rf_we=0). Requesters still holding valid re-arbitrate from ptr=0 after reset release.
- Simultaneous valids at reset-default ptr: the order is ALU, load, mul/div.

## Configuration
- WB_TRACE_EN defined: on each transfer, a simulation-only `$display` prints the cycle count, source name, rd and data in decimal. A suppressed x0 write prints "x0 dropped".
- WB_TRACE_EN undefined: no display code is compiled. Port behaviour is identical in both cases.

## Test plan
- Reset, then alu_valid=1, rd=5, data=42 for one cycle -> alu_ready=1 in T; in T+1 rf_we=1, rf_waddr=5, rf_wdata=42, wb_src=0; in T+2 rf_we=0.
- All three valid and held (rd 1/2/3, data 10/20/30) -> grants ALU, load, mul/div on consecutive cycles. Writes 10, 20, 30 appear in T+1..T+3. conflict_cnt=2 after the first two cycles.
- ld_valid=1 with rd=0, data=99 -> ld_ready=1 and ptr advances to 2; next cycle rf_we=0, wb_src=3, and rf_waddr/rf_wdata keep their previous values.
- Assert rst_n=0 in the cycle after an md handshake -> rf_we=0 immediately and conflict_cnt=0. After release, an ALU and mul/div both valid -> ALU is granted first.
- Hold alu_valid and md_valid for 2^CNT_W+3 cycles -> conflict_cnt saturates at 0xFFFF. Pulse clr_cnt together with a conflict cycle -> 0.
- Alternate ld_valid and md_valid with ALU valid continuously -> ALU is never starved more than 2 cycles, and each write appears exactly once.
